img_loader: RTL
===============

IMG_LOADER -- requirements
Module: img_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 8: pixel width in bits.
REQ-002 Parameter IMG_DIM, default 28: image width and height in pixels; even, and at most 2*3*32.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port srst  input  1: synchronous, active-high reset.
REQ-005 Port load_start  input  1: one-cycle start pulse.
REQ-006 Port pix_valid  input  1: upstream pixel valid.
REQ-007 Port pix_data  input  DATA_WIDTH: pixel value, unsigned, row-major stream order.
REQ-008 Port pix_ready  output  1: loader accepts pix_data when high.
REQ-009 Port sram_write_enable_a0..a8  output  1 each: SRAM_a bank write enables, active-low.
REQ-010 Port sram_bytemask_a  output  4: byte-lane mask; bit i covers wdata[8i+7:8i]; 0 means write.
REQ-011 Port sram_waddr_a  output  10: write address shared by all nine banks.
REQ-012 Port sram_wdata_a  output  4*DATA_WIDTH: write data.
REQ-013 Port busy  output  1: high in LOAD and DONE.
REQ-014 Port load_done  output  1: one-cycle pulse when the full image has been written.

Function
REQ-015 FSM states: IDLE, LOAD, DONE.
- IDLE -> LOAD on load_start.
- LOAD -> DONE on the cycle the final write strobe is driven.
- DONE -> IDLE after exactly one cycle.
REQ-016 pix_ready equals (state==LOAD) and (not all IMG_DIM*IMG_DIM pixels yet accepted); it is combinational from registered state only.
REQ-017 A pixel is accepted on any rising edge where pix_valid and pix_ready are both high; gaps in pix_valid stall the loader without losing position.
REQ-018 Pixel (r,c) maps as follows; tr=r/2, tc=c/2.
- bank = (tr mod 3)*3 + (tc mod 3).
- address = (tr/3)*ceil(IMG_DIM/6) + tc/3.
- byte lane k = (r mod 2)*2 + (c mod 2).
REQ-019 Bank, address and lane are tracked with incremental row/column, mod-3 and div-3 counters; no divider or multiplier is used.
REQ-020 Lane k is written to wdata bits [8(3-k)+7 : 8(3-k)], i.e. lane 0 is the MSB byte; sram_bytemask_a bit (3-k) is 0 and all other bits are 1.
REQ-021 sram_wdata_a carries the pixel replicated in all four lanes.
REQ-022 Write latency is one cycle: a pixel accepted at edge N drives exactly one bank enable low, plus address, mask and data, during cycle N+1; all these outputs are registered.
REQ-023 In any cycle without a write strobe:
- all nine write enables are 1 and sram_bytemask_a is 4'b1111;
- sram_waddr_a and sram_wdata_a hold their previous values.
REQ-024 The final pixel's strobe cycle is the last LOAD cycle; load_done is high for the single DONE cycle that follows.
REQ-025 load_start is ignored while busy; load_start in the DONE cycle is ignored.
REQ-026 pix_valid in IDLE or DONE is ignored and is not counted.
REQ-027 All position counters clear on entering LOAD, so a new load restarts at pixel (0,0).

Reset
REQ-028 srst high forces, at the next edge:
- state IDLE and all position counters 0;
- write enables 1, bytemask 4'b1111, waddr 0, wdata 0;
- busy 0, load_done 0 (and therefore pix_ready 0).
REQ-029 srst takes priority over load_start and pix_valid in the same cycle.
REQ-030 If srst is asserted mid-LOAD, the partial image is abandoned, no further strobes are issued, and load_done is not pulsed.

Configuration
REQ-031 The feature is controlled by the macro IMG_LOADER_SIGNED_EN.
- Defined: each accepted pixel has its MSB inverted (pixel-128, two's complement) before being written.
- Undefined: the pixel is written unchanged.
- Timing and addressing are identical in both builds.

Verification
REQ-032 Reset: assert srst mid-LOAD after 100 pixels -> next cycle all enables 1, mask 4'b1111, busy 0; no load_done; a restarted load writes pixel 0 to bank0 addr0.
REQ-033 Mapping: stream 784 pixels with pix_data=index[7:0] and pix_valid held high; check:
- pixel 0 -> a0, addr 0, mask 4'b0111;
- pixel 1 -> a0, addr 0, mask 4'b1011;
- pixel 62 (r2,c6) -> a3, addr 1, mask 4'b0111;
- pixel 783 (r27,c27) -> a4, addr 24, mask 4'b1110.
REQ-034 Timing: with pix_valid held high, the load completes 785 cycles after the load_start edge; load_done pulses exactly once, and busy falls the cycle after.
REQ-035 Backpressure: toggle pix_valid randomly at 50% -> identical write sequence to REQ-033 (ignoring timing), no duplicate or missing strobes, exactly 784 strobes.
REQ-036 Spurious inputs: pix_valid high in IDLE, and load_start pulsed mid-LOAD -> no strobes in IDLE and no counter restart.
REQ-037 Signed build, with IMG_LOADER_SIGNED_EN defined: pix_data 8'h00 -> wdata 32'h80808080; pix_data 8'hFF -> wdata 32'h7F7F7F7F.

Source files
------------

// File: rtl/img_loader.sv
// -----------------------------------------------------------------------------
// img_loader
//
// Streams a square IMG_DIM x IMG_DIM image (row-major, valid/ready handshake)
// into nine SRAM_a banks. The image is tiled into 2x2 pixel quads. Each quad
// occupies one 32-bit word. Quads are spread over a 3x3 bank pattern, so any
// 3x3 window of quads can be read from nine distinct banks in parallel.
//
// Mapping of pixel (r,c), with tr=r/2 and tc=c/2:
//   bank    = (tr mod 3)*3 + (tc mod 3)
//   address = (tr/3)*ceil(IMG_DIM/6) + tc/3
//   lane k  = (r mod 2)*2 + (c mod 2), where lane 0 is the MSB byte
// These values come from incremental counters. The design uses no divider and
// no multiplier.
//
// Ports
//   clk                    : clock; all state updates on the rising edge
//   srst                   : synchronous active-high reset
//   load_start             : one-cycle pulse that starts a load from IDLE
//   pix_valid / pix_data   : upstream pixel stream
//   pix_ready              : pixel accepted when pix_valid && pix_ready
//   sram_write_enable_a0..8: per-bank write enables, active-low
//   sram_bytemask_a        : byte-lane mask, 0 = write that lane
//   sram_waddr_a           : write address, shared by all banks
//   sram_wdata_a           : pixel replicated in all four lanes
//   busy                   : high in LOAD and DONE
//   load_done              : one-cycle pulse after the full image is written
//
// Build option
//   IMG_LOADER_SIGNED_EN   : when defined, each pixel has its MSB inverted
//                            (pixel-128 in two's complement) before the write.
// -----------------------------------------------------------------------------
module img_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_DIM    = 28
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    load_start,
    input  logic                    pix_valid,
    input  logic [DATA_WIDTH-1:0]   pix_data,
    output logic                    pix_ready,
    output logic                    sram_write_enable_a0,
    output logic                    sram_write_enable_a1,
    output logic                    sram_write_enable_a2,
    output logic                    sram_write_enable_a3,
    output logic                    sram_write_enable_a4,
    output logic                    sram_write_enable_a5,
    output logic                    sram_write_enable_a6,
    output logic                    sram_write_enable_a7,
    output logic                    sram_write_enable_a8,
    output logic [3:0]              sram_bytemask_a,
    output logic [9:0]              sram_waddr_a,
    output logic [4*DATA_WIDTH-1:0] sram_wdata_a,
    output logic                    busy,
    output logic                    load_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Number of words in one band of three quad-rows: ceil(IMG_DIM/6).
    localparam logic [9:0] ADDR_STRIDE = 10'((IMG_DIM + 5) / 6);
    localparam logic [7:0] LAST_POS    = 8'(IMG_DIM - 1);

    logic [1:0] state;
    logic [7:0] row, col;          // pixel position of the next accepted pixel
    logic       r_lsb, c_lsb;      // r mod 2, c mod 2
    logic [1:0] tr_mod3, tc_mod3;  // quad row/col mod 3
    logic [9:0] tc_div3;           // quad col / 3
    logic [9:0] row_base;          // (tr/3) * ADDR_STRIDE, grown by addition
    logic       all_accepted;      // every pixel of the image has been taken

    logic [8:0] we_n;
    logic       accept;
    logic       last_pix;
    logic [3:0] bank_idx;
    logic [1:0] lane;
    logic [DATA_WIDTH-1:0] pix_w;

    assign pix_ready = (state == S_LOAD) && !all_accepted;
    assign accept    = pix_valid && pix_ready;
    assign last_pix  = (row == LAST_POS) && (col == LAST_POS);
    assign busy      = (state != S_IDLE);
    assign load_done = (state == S_DONE);

    // bank = tr_mod3*3 + tc_mod3, written as shift-and-add.
    assign bank_idx = {1'b0, tr_mod3, 1'b0} + {2'b00, tr_mod3} + {2'b00, tc_mod3};
    assign lane     = {r_lsb, c_lsb};

`ifdef IMG_LOADER_SIGNED_EN
    // Inverting the MSB maps unsigned 0..255 onto two's-complement -128..127.
    assign pix_w = {~pix_data[DATA_WIDTH-1], pix_data[DATA_WIDTH-2:0]};
`else
    assign pix_w = pix_data;
`endif

    assign sram_write_enable_a0 = we_n[0];
    assign sram_write_enable_a1 = we_n[1];
    assign sram_write_enable_a2 = we_n[2];
    assign sram_write_enable_a3 = we_n[3];
    assign sram_write_enable_a4 = we_n[4];
    assign sram_write_enable_a5 = we_n[5];
    assign sram_write_enable_a6 = we_n[6];
    assign sram_write_enable_a7 = we_n[7];
    assign sram_write_enable_a8 = we_n[8];

    // NOTE: all state here uses non-blocking assignments. Every register then
    // sees the values from before the edge, no matter the statement order.
    always_ff @(posedge clk) begin
        if (srst) begin
            state           <= S_IDLE;
            row             <= '0;
            col             <= '0;
            r_lsb           <= 1'b0;
            c_lsb           <= 1'b0;
            tr_mod3         <= '0;
            tc_mod3         <= '0;
            tc_div3         <= '0;
            row_base        <= '0;
            all_accepted    <= 1'b0;
            we_n            <= '1;
            sram_bytemask_a <= 4'hF;
            sram_waddr_a    <= '0;
            sram_wdata_a    <= '0;
        end else begin
            // Strobes last one cycle. Address and data hold between strobes.
            we_n            <= '1;
            sram_bytemask_a <= 4'hF;

            case (state)
                S_IDLE: begin
                    if (load_start) begin
                        state        <= S_LOAD;
                        row          <= '0;
                        col          <= '0;
                        r_lsb        <= 1'b0;
                        c_lsb        <= 1'b0;
                        tr_mod3      <= '0;
                        tc_mod3      <= '0;
                        tc_div3      <= '0;
                        row_base     <= '0;
                        all_accepted <= 1'b0;
                    end
                end

                S_LOAD: begin
                    // all_accepted rises on the edge that launches the final
                    // strobe. That strobe cycle is therefore the last LOAD cycle.
                    if (all_accepted) begin
                        state <= S_DONE;
                    end

                    if (accept) begin
                        we_n            <= ~(9'd1 << bank_idx);
                        sram_bytemask_a <= ~(4'b1000 >> lane);
                        sram_waddr_a    <= row_base + tc_div3;
                        sram_wdata_a    <= {4{pix_w}};

                        if (last_pix) begin
                            all_accepted <= 1'b1;
                        end

                        if (col == LAST_POS) begin
                            col     <= '0;
                            c_lsb   <= 1'b0;
                            tc_mod3 <= '0;
                            tc_div3 <= '0;
                            row     <= row + 8'd1;
                            r_lsb   <= ~r_lsb;
                            if (r_lsb) begin
                                if (tr_mod3 == 2'd2) begin
                                    tr_mod3  <= '0;
                                    row_base <= row_base + ADDR_STRIDE;
                                end else begin
                                    tr_mod3 <= tr_mod3 + 2'd1;
                                end
                            end
                        end else begin
                            col   <= col + 8'd1;
                            c_lsb <= ~c_lsb;
                            if (c_lsb) begin
                                if (tc_mod3 == 2'd2) begin
                                    tc_mod3 <= '0;
                                    tc_div3 <= tc_div3 + 10'd1;
                                end else begin
                                    tc_mod3 <= tc_mod3 + 2'd1;
                                end
                            end
                        end
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
